ublock_share_loader: RTL and testbench

UBLOCK_SHARE_LOADER -- requirements
Module: ublock_share_loader

---
 rtl/ublock_pkg.sv | 8 +
 rtl/ublock_share_loader_if.sv | 16 +
 rtl/ublock_share_split.sv | 12 +
 rtl/ublock_share_loader.sv | 60 ++++++
 tb/tb_ublock_share_loader.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ublock_pkg.sv
// ublock_pkg: shared FSM state encoding, 128-bit datapath width and rnd slice positions
package ublock_pkg;
  localparam int W = 128;
  localparam int RW = 256;
  localparam int PM_LSB = 0;
  localparam int KM_LSB = 128;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_OUT} state_t;
endpackage

// File: rtl/ublock_share_loader_if.sv
// ublock_share_loader_if: request/engine/result bundle; slave = loader view, master = environment view
interface ublock_share_loader_if;
  import ublock_pkg::*;
  logic in_valid, in_ready, eng_start, eng_occupied, eng_done, out_valid, out_ready, err;
  logic [W-1:0] in_plain, in_key, eng_plain0, eng_plain1, eng_key0, eng_key1;
  logic [W-1:0] eng_cipher0, eng_cipher1, out_cipher0, out_cipher1;
  logic [RW-1:0] rnd;
  modport slave (
    input in_valid, in_plain, in_key, rnd, eng_occupied, eng_done, eng_cipher0, eng_cipher1, out_ready,
    output in_ready, eng_start, eng_plain0, eng_plain1, eng_key0, eng_key1, out_valid, out_cipher0, out_cipher1, err
  );
  modport master (
    output in_valid, in_plain, in_key, rnd, eng_occupied, eng_done, eng_cipher0, eng_cipher1, out_ready,
    input in_ready, eng_start, eng_plain0, eng_plain1, eng_key0, eng_key1, out_valid, out_cipher0, out_cipher1, err
  );
endinterface

// File: rtl/ublock_share_split.sv
// ublock_share_split: combinational XOR masking; i_value/i_mask in, o_share0 = value^mask, o_share1 = mask
module ublock_share_split
  import ublock_pkg::*;
(
  input  logic [W-1:0] i_value,
  input  logic [W-1:0] i_mask,
  output logic [W-1:0] o_share0,
  output logic [W-1:0] o_share1
);
  assign o_share0 = i_value ^ i_mask;
  assign o_share1 = i_mask;
endmodule

// File: rtl/ublock_share_loader.sv
// ublock_share_loader: masks a request into two shares, starts the engine, registers the shared result; ports clk, rst (async high), bus (slave); UBLOCK_OUT_REMASK_EN remasks output shares with rnd[127:0]
module ublock_share_loader
  import ublock_pkg::*;
#(
  parameter int WD_CYCLES = 1023
) (
  input logic clk,
  input logic rst,
  ublock_share_loader_if.slave bus
);
  localparam logic [9:0] WD = 10'(WD_CYCLES);
  state_t r_state, w_next;
  logic [W-1:0] r_p0, r_p1, r_k0, r_k1, r_c0, r_c1;
  logic [W-1:0] w_p0, w_p1, w_k0, w_k1, w_c0, w_c1;
  logic [9:0] r_wd;
  logic r_err, w_acc, w_go, w_cap, w_rel;
  ublock_share_split u_plain (.i_value(bus.in_plain), .i_mask(bus.rnd[PM_LSB +: W]), .o_share0(w_p0), .o_share1(w_p1));
  ublock_share_split u_key (.i_value(bus.in_key), .i_mask(bus.rnd[KM_LSB +: W]), .o_share0(w_k0), .o_share1(w_k1));
`ifdef UBLOCK_OUT_REMASK_EN
  assign w_c0 = bus.eng_cipher0 ^ bus.rnd[PM_LSB +: W];
  assign w_c1 = bus.eng_cipher1 ^ bus.rnd[PM_LSB +: W];
`else
  assign w_c0 = bus.eng_cipher0;
  assign w_c1 = bus.eng_cipher1;
`endif
  assign w_acc = r_state == S_IDLE && bus.in_valid;
  assign w_go = r_state == S_START && !bus.eng_occupied;
  assign w_cap = r_state == S_RUN && bus.eng_done;
  assign w_rel = r_state == S_OUT && bus.out_ready;
  always_comb begin
    bus.in_ready = r_state == S_IDLE;
    bus.eng_start = w_go;
    w_next = w_acc ? S_START : w_go ? S_RUN : w_cap ? S_OUT : w_rel ? S_IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      {r_p0, r_p1, r_k0, r_k1, r_c0, r_c1} <= '0;
      r_wd <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) {r_p0, r_p1, r_k0, r_k1} <= {w_p0, w_p1, w_k0, w_k1};
      if (w_go) r_wd <= '0;
      else if (r_state == S_RUN && !bus.eng_done && r_wd != WD) begin
        r_wd <= r_wd + 10'd1;
        if (r_wd == WD - 10'd1) r_err <= 1'b1;
      end
      if (w_cap) {r_c0, r_c1} <= {w_c0, w_c1};
    end
  end
  assign bus.eng_plain0 = r_p0;
  assign bus.eng_plain1 = r_p1;
  assign bus.eng_key0 = r_k0;
  assign bus.eng_key1 = r_k1;
  assign bus.out_valid = r_state == S_OUT;
  assign bus.out_cipher0 = r_c0;
  assign bus.out_cipher1 = r_c1;
  assign bus.err = r_err;
endmodule

// File: tb/tb_ublock_share_loader.sv
// tb_ublock_share_loader: randomized self-checking bench with stub engine and share-level reference model
module tb_ublock_share_loader;
  localparam logic [127:0] A5 = {16{8'hA5}};
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int stub_n = 20;
  int stub_cnt;
  logic stub_done, stray_done;
  logic [127:0] stub_c0, stub_c1, stray_c;
  always #5 clk = ~clk;
  ublock_share_loader_if ifc();
  ublock_share_loader_if ifw();
  ublock_share_loader dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  ublock_share_loader #(.WD_CYCLES(8)) dut_wd (.clk(clk), .rst(rst), .bus(ifw.slave));
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt <= 0;
      stub_done <= 1'b0;
      stub_c0 <= '0;
      stub_c1 <= '0;
    end else begin
      stub_done <= 1'b0;
      if (ifc.eng_start) stub_cnt <= stub_n - 1;
      else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_done <= 1'b1;
          stub_c0 <= ifc.eng_plain0 ^ A5;
          stub_c1 <= ifc.eng_plain1;
        end
      end
    end
  end
  assign ifc.eng_done = stub_done | stray_done;
  assign ifc.eng_cipher0 = stray_done ? stray_c : stub_c0;
  assign ifc.eng_cipher1 = stray_done ? ~stray_c : stub_c1;
  always @(negedge clk) if (ifc.eng_start === 1'b1) starts++;
  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic logic [127:0] remask(input logic [127:0] v, input logic [127:0] m);
`ifdef UBLOCK_OUT_REMASK_EN
    return v ^ m;
`else
    return v;
`endif
  endfunction
  task automatic run_txn(input logic [127:0] plain, input logic [127:0] key, input logic [255:0] r0,
                         input logic [255:0] r1, input int occ, input int n, input int bp);
    logic [127:0] e_p0, e_p1, e_k0, e_k1, e_c0, e_c1;
    int s0, lat;
    bit seen;
    e_p0 = plain ^ r0[127:0];
    e_p1 = r0[127:0];
    e_k0 = key ^ r0[255:128];
    e_k1 = r0[255:128];
    e_c0 = remask(e_p0 ^ A5, r1[127:0]);
    e_c1 = remask(e_p1, r1[127:0]);
    stub_n = n;
    @(posedge clk) #1;
    ifc.in_valid = 1'b1;
    ifc.in_plain = plain;
    ifc.in_key = key;
    ifc.rnd = r0;
    ifc.eng_occupied = occ > 0;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", ifc.in_ready); end
    @(posedge clk) #1;
    ifc.in_valid = 1'b0;
    ifc.rnd = r1;
    s0 = starts;
    for (int i = 0; i < occ; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.eng_start !== 1'b0 || ifc.in_ready !== 1'b0) begin
        errors++; $display("FAIL occ_hold cyc %0d start %b ready %b exp 0 0", i, ifc.eng_start, ifc.in_ready);
      end
      @(posedge clk) #1;
    end
    ifc.eng_occupied = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.eng_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b exp 1", ifc.eng_start); end
    checks++;
    if (ifc.eng_plain0 !== e_p0 || ifc.eng_plain1 !== e_p1) begin
      errors++; $display("FAIL plain_shares got %h %h exp %h %h", ifc.eng_plain0, ifc.eng_plain1, e_p0, e_p1);
    end
    checks++;
    if (ifc.eng_key0 !== e_k0 || ifc.eng_key1 !== e_k1) begin
      errors++; $display("FAIL key_shares got %h %h exp %h %h", ifc.eng_key0, ifc.eng_key1, e_k0, e_k1);
    end
    seen = 0;
    lat = 0;
    for (int j = 1; j <= n + 5 && !seen; j++) begin
      @(negedge clk);
      if (ifc.eng_done === 1'b1) begin
        checks++;
        if (ifc.eng_plain0 !== e_p0 || ifc.eng_key1 !== e_k1) begin
          errors++; $display("FAIL shares_at_done got %h %h exp %h %h", ifc.eng_plain0, ifc.eng_key1, e_p0, e_k1);
        end
      end
      if (ifc.out_valid === 1'b1) begin seen = 1; lat = j; end
    end
    checks++;
    if (!seen || lat != n + 1) begin errors++; $display("FAIL out_latency got %0d exp %0d", lat, n + 1); end
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL start_count got %0d exp 1", starts - s0); end
    checks++;
    if (ifc.out_cipher0 !== e_c0 || ifc.out_cipher1 !== e_c1) begin
      errors++; $display("FAIL out_shares got %h %h exp %h %h", ifc.out_cipher0, ifc.out_cipher1, e_c0, e_c1);
    end
    checks++;
    if ((ifc.out_cipher0 ^ ifc.out_cipher1) !== (plain ^ A5)) begin
      errors++; $display("FAIL recombined got %h exp %h", ifc.out_cipher0 ^ ifc.out_cipher1, plain ^ A5);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.out_cipher0 !== e_c0 || ifc.out_cipher1 !== e_c1) begin
        errors++; $display("FAIL backpressure cyc %0d valid %b ready %b c0 %h exp 1 0 %h", i, ifc.out_valid, ifc.in_ready, ifc.out_cipher0, e_c0);
      end
    end
    ifc.out_ready = 1'b1;
    @(posedge clk) #1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++; $display("FAIL after_handshake valid %b ready %b exp 0 1", ifc.out_valid, ifc.in_ready);
    end
  endtask
  task automatic test_reset();
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.eng_start !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.err !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl ready %b start %b valid %b err %b exp 1 0 0 0", ifc.in_ready, ifc.eng_start, ifc.out_valid, ifc.err);
    end
    checks++;
    if ({ifc.eng_plain0, ifc.eng_plain1, ifc.eng_key0, ifc.eng_key1, ifc.out_cipher0, ifc.out_cipher1} !== '0) begin
      errors++; $display("FAIL reset_regs p0 %h c0 %h exp 0", ifc.eng_plain0, ifc.out_cipher0);
    end
    checks++;
    if (ifw.err !== 1'b0 || ifw.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wd err %b ready %b exp 0 1", ifw.err, ifw.in_ready);
    end
  endtask
  task automatic test_basic();
    run_txn(128'h0123456789abcdef0123456789abcdef, r128(), '0, '0, 0, 20, 0);
  endtask
  task automatic test_occupied();
    run_txn(r128(), r128(), {r128(), r128()}, {r128(), r128()}, 5, 4, 0);
  endtask
  task automatic test_backpressure();
    run_txn(r128(), r128(), {r128(), r128()}, {r128(), r128()}, 0, 3, 10);
  endtask
  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_txn(r128(), r128(), {r128(), r128()}, {r128(), r128()}, $urandom_range(0, 3), $urandom_range(2, 8), $urandom_range(0, 3));
  endtask
  task automatic test_stray_done();
    logic [127:0] c0, c1;
    c0 = ifc.out_cipher0;
    c1 = ifc.out_cipher1;
    @(posedge clk) #1;
    stray_c = r128();
    stray_done = 1'b1;
    @(posedge clk) #1;
    stray_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_cipher0 !== c0 || ifc.out_cipher1 !== c1) begin
      errors++; $display("FAIL stray_done valid %b ready %b c0 %h exp 0 1 %h", ifc.out_valid, ifc.in_ready, ifc.out_cipher0, c0);
    end
  endtask
  task automatic wd_accept();
    @(posedge clk) #1;
    ifw.in_valid = 1'b1;
    ifw.in_plain = r128();
    ifw.in_key = r128();
    @(posedge clk) #1;
    ifw.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifw.eng_start !== 1'b1) begin errors++; $display("FAIL wd_start got %b exp 1", ifw.eng_start); end
  endtask
  task automatic test_wd_boundary();
    logic [127:0] c;
    c = r128();
    wd_accept();
    repeat (8) @(negedge clk);
    checks++;
    if (ifw.err !== 1'b0) begin errors++; $display("FAIL wdb_pre err %b exp 0", ifw.err); end
    ifw.eng_done = 1'b1;
    ifw.eng_cipher0 = c;
    ifw.eng_cipher1 = ~c;
    @(posedge clk) #1;
    ifw.eng_done = 1'b0;
    @(negedge clk);
    checks++;
    if (ifw.out_valid !== 1'b1 || ifw.err !== 1'b0) begin
      errors++; $display("FAIL wdb_capture valid %b err %b exp 1 0", ifw.out_valid, ifw.err);
    end
    checks++;
    if (ifw.out_cipher0 !== remask(c, ifw.rnd[127:0]) || ifw.out_cipher1 !== remask(~c, ifw.rnd[127:0])) begin
      errors++; $display("FAIL wdb_data got %h exp %h", ifw.out_cipher0, remask(c, ifw.rnd[127:0]));
    end
    ifw.out_ready = 1'b1;
    @(posedge clk) #1;
    ifw.out_ready = 1'b0;
  endtask
  task automatic test_watchdog();
    wd_accept();
    repeat (8) @(negedge clk);
    checks++;
    if (ifw.err !== 1'b0) begin errors++; $display("FAIL wd_early err %b exp 0", ifw.err); end
    @(negedge clk);
    checks++;
    if (ifw.err !== 1'b1) begin errors++; $display("FAIL wd_set err %b exp 1", ifw.err); end
    repeat (15) @(negedge clk);
    checks++;
    if (ifw.err !== 1'b1 || ifw.out_valid !== 1'b0 || ifw.in_ready !== 1'b0) begin
      errors++; $display("FAIL wd_sticky err %b valid %b ready %b exp 1 0 0", ifw.err, ifw.out_valid, ifw.in_ready);
    end
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifw.err !== 1'b0 || ifw.in_ready !== 1'b1) begin
      errors++; $display("FAIL wd_clear err %b ready %b exp 0 1", ifw.err, ifw.in_ready);
    end
  endtask
  task automatic test_reset_run();
    stub_n = 20;
    @(posedge clk) #1;
    ifc.in_valid = 1'b1;
    ifc.in_plain = r128();
    ifc.in_key = r128();
    ifc.rnd = {r128(), r128()};
    @(posedge clk) #1;
    ifc.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.eng_start !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.err !== 1'b0) begin
      errors++; $display("FAIL rst_run_ctrl ready %b start %b valid %b err %b exp 1 0 0 0", ifc.in_ready, ifc.eng_start, ifc.out_valid, ifc.err);
    end
    checks++;
    if ({ifc.eng_plain0, ifc.eng_plain1, ifc.eng_key0, ifc.eng_key1, ifc.out_cipher0, ifc.out_cipher1} !== '0) begin
      errors++; $display("FAIL rst_run_regs p0 %h c0 %h exp 0", ifc.eng_plain0, ifc.out_cipher0);
    end
    @(posedge clk) #1;
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifc.out_valid !== 1'b0) begin
        checks++; errors++; $display("FAIL rst_run_discard cyc %0d valid %b exp 0", i, ifc.out_valid);
        break;
      end
    end
    run_txn(r128(), r128(), {r128(), r128()}, {r128(), r128()}, 1, 6, 2);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    stray_done = 1'b0;
    stray_c = '0;
    {ifc.in_valid, ifc.eng_occupied, ifc.out_ready} = '0;
    {ifc.in_plain, ifc.in_key, ifc.rnd} = '0;
    {ifw.in_valid, ifw.eng_occupied, ifw.out_ready, ifw.eng_done} = '0;
    {ifw.in_plain, ifw.in_key, ifw.eng_cipher0, ifw.eng_cipher1} = '0;
    ifw.rnd = {r128(), r128()};
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic();
    test_occupied();
    test_backpressure();
    test_random();
    test_stray_done();
    test_wd_boundary();
    test_watchdog();
    test_reset_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
